// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the registered N-to-1 selector.
package mux_arb_pkg;

  localparam int MODE_SEL = 0;  // steered by select_i
  localparam int MODE_RR  = 1;  // round-robin arbitration

  // Index width for n channels, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr_i,
// wrapping to channel 0 when nothing at or above the pointer is requesting.
module rr_arbiter #(
  parameter int CH   = 4,
  parameter int SELW = 2
) (
  input  logic [CH-1:0]   req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic            en_i,
  output logic [CH-1:0]   gnt_o,
  output logic [SELW-1:0] gnt_idx_o
);

  logic [CH-1:0] mask;
  logic [CH-1:0] masked;
  logic [CH-1:0] pick;

  always_comb begin
    mask = '0;
    for (int k = 0; k < CH; k++) begin
      mask[k] = (SELW'(k) >= ptr_i);
    end
  end

  // Requests at or above the pointer win; otherwise fall back to the
  // unmasked vector, which yields the wrapped search order.
  assign masked = req_i & mask;
  assign pick   = (|masked) ? masked : req_i;

  // Descending scan leaves the lowest set bit of pick as the winner.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (en_i && pick[k]) begin
        gnt_o     = '0;
        gnt_o[k]  = 1'b1;
        gnt_idx_o = SELW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// Registered N-to-1 selector with valid/ready on every channel and on the
// output; channel choice is steered by select_i or round-robin arbitrated.
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int  SIZE = 32,
  parameter int  CH   = 4,
  parameter int  MODE = MODE_SEL,
  localparam int SELW = clog2(CH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CH-1:0]      valid_i,
  input  logic [CH*SIZE-1:0] data_i,
  output logic [CH-1:0]      ready_o,
  input  logic [SELW-1:0]    select_i,
  output logic               valid_o,
  output logic [SIZE-1:0]    data_o,
  output logic [SELW-1:0]    sel_o,
  input  logic               ready_i
);

  logic            free;
  logic            grant_en;
  logic            xfer;
  logic [CH-1:0]   gnt;
  logic [SELW-1:0] gnt_idx;
  logic [SIZE-1:0] gnt_data;

  logic            valid_q, valid_d;
  logic [SIZE-1:0] data_q,  data_d;
  logic [SELW-1:0] sel_q,   sel_d;
  logic [SELW-1:0] ptr_q,   ptr_d;

  // The register can take a word when empty or when it drains this cycle.
  // Holding reset low also blocks grants so no source loses a word to it.
  assign free     = !valid_q || ready_i;
  assign grant_en = free && rst_i;

  if (MODE == MODE_RR) begin : g_rr
    logic unused_select;
    assign unused_select = ^select_i;

    rr_arbiter #(
      .CH   (CH),
      .SELW (SELW)
    ) u_arb (
      .req_i     (valid_i),
      .ptr_i     (ptr_q),
      .en_i      (grant_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
    );
  end else begin : g_sel
    // Out-of-range select values match no channel and so grant nothing.
    always_comb begin
      gnt = '0;
      for (int k = 0; k < CH; k++) begin
        if (grant_en && (select_i == SELW'(k)) && valid_i[k]) gnt[k] = 1'b1;
      end
    end
    assign gnt_idx = select_i;
  end

  assign xfer = |gnt;

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt[k]) gnt_data = data_i[k*SIZE +: SIZE];
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = gnt_data;
      sel_d   = gnt_idx;
      ptr_d   = (gnt_idx == SELW'(CH - 1)) ? '0 : gnt_idx + SELW'(1);
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the data register is reset along with valid because data_o is
  // visible at the port and must read zero during reset, not stale contents.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ready_o = gnt;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Scoreboard bench: steered and round-robin 4-channel instances plus a
// 3-channel steered instance for the out-of-range select case.
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int err = 0;
  int chk = 0;

  typedef struct {
    int          sel;
    logic [31:0] data;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic         rst_n;
    logic [3:0]   valid_i;
    logic [3:0]   ready_o;
    logic [127:0] data_i;
    logic [1:0]   select_i;
    logic [1:0]   sel_o;
    logic         valid_o;
    logic         ready_i;
    logic [31:0]  data_o;
    bit           done = 1'b0;
    exp_t         sb[$];
    bit           m_valid;
    int           m_ptr;
    int           last_g;

    mux_arb_nto1 #(.SIZE(32), .CH(4), .MODE(d)) u_dut (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .valid_i  (valid_i),
      .data_i   (data_i),
      .ready_o  (ready_o),
      .select_i (select_i),
      .valid_o  (valid_o),
      .data_o   (data_o),
      .sel_o    (sel_o),
      .ready_i  (ready_i)
    );

    task automatic offer(input int k, input logic [31:0] w);
      valid_i[k]          = 1'b1;
      data_i[k*32 +: 32]  = w;
    endtask

    // One cycle: model the grant from the rules, compare ready_o, queue the
    // expected output word, then retire the granted source after the edge.
    task automatic step();
      int g;
      bit free;
      @(negedge clk);
      free = !m_valid || ready_i;
      g = -1;
      if (free) begin
        if (d == 0) begin
          if (valid_i[select_i]) g = int'(select_i);
        end else begin
          for (int i = 0; i < 4; i++)
            if (g < 0 && valid_i[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
        end
      end
      check($sformatf("m%0d_ready_o", d), 64'(ready_o), (g < 0) ? 64'd0 : (64'd1 << g));
      if (g >= 0) begin
        sb.push_back('{g, data_i[g*32 +: 32]});
        m_ptr   = (g + 1) % 4;
        m_valid = 1'b1;
      end else if (ready_i) begin
        m_valid = 1'b0;
      end
      last_g = g;
      @(posedge clk);
      #1;
      if (g >= 0) valid_i[g] = 1'b0;
    endtask

    initial begin
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n === 1'b1 && valid_o && ready_i) begin
          if (sb.size() == 0) begin
            check($sformatf("m%0d_unexpected_out", d), 64'(valid_o), 64'd0);
          end else begin
            e = sb.pop_front();
            check($sformatf("m%0d_out_sel_data", d), {30'b0, sel_o, data_o},
                  {30'b0, 2'(e.sel), e.data});
          end
        end
      end
    end

    initial begin
      logic [31:0] held;
      rst_n = 1'b0; valid_i = '0; data_i = '0; select_i = '0; ready_i = 1'b0;
      m_valid = 1'b0; m_ptr = 0; last_g = -1;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("m%0d_reset_valid", d), 64'(valid_o), 64'd0);
      check($sformatf("m%0d_reset_data", d), 64'(data_o), 64'd0);
      check($sformatf("m%0d_reset_sel", d), 64'(sel_o), 64'd0);
      rst_n = 1'b1;

      if (d == 0) begin
        select_i = 2'd2; ready_i = 1'b1;
        offer(1, $urandom);
        offer(2, 32'hDEADBEEF);
        step();
        check("m0_dir_valid", 64'(valid_o), 64'd1);
        check("m0_dir_data", 64'(data_o), 64'hDEADBEEF);
        check("m0_dir_sel", 64'(sel_o), 64'd2);
        select_i = 2'd3;
        step();
        check("m0_nogrant_valid", 64'(valid_o), 64'd0);
        select_i = 2'd1;
        step();
        check("m0_ch1_sel", 64'(sel_o), 64'd1);
      end else begin
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) offer(k, $urandom);
        for (int i = 0; i < 8; i++) begin
          step();
          check($sformatf("m1_rr_sel_%0d", i), 64'(sel_o), 64'(i % 4));
          check($sformatf("m1_rr_valid_%0d", i), 64'(valid_o), 64'd1);
          if (i < 4 && last_g >= 0) offer(last_g, $urandom);
        end
        offer(0, $urandom);
        offer(2, $urandom);
        step();
        check("m1_sparse_wrap", 64'(sel_o), 64'd0);
        step();
        check("m1_sparse_next", 64'(sel_o), 64'd2);

        for (int k = 0; k < 4; k++) offer(k, $urandom);
        step();
        check("m1_bp_first", 64'(sel_o), 64'd3);
        ready_i = 1'b0;
        held = data_o;
        for (int i = 0; i < 3; i++) begin
          step();
          check($sformatf("m1_bp_hold_data_%0d", i), 64'(data_o), 64'(held));
          check($sformatf("m1_bp_hold_valid_%0d", i), 64'(valid_o), 64'd1);
        end
        ready_i = 1'b1;
        step();
        check("m1_bp_refill_valid", 64'(valid_o), 64'd1);
        check("m1_bp_refill_sel", 64'(sel_o), 64'd0);
      end

      for (int i = 0; i < 400; i++) begin
        for (int k = 0; k < 4; k++)
          if (!valid_i[k] && $urandom_range(1) == 1) offer(k, $urandom);
        if (d == 0) select_i = 2'($urandom_range(3));
        ready_i = ($urandom_range(9) < 7);
        step();
      end

      // Reset while the output register holds a word.
      for (int k = 0; k < 4; k++) if (!valid_i[k]) offer(k, $urandom);
      select_i = 2'd0; ready_i = 1'b1;
      step();
      check($sformatf("m%0d_prereset_valid", d), 64'(valid_o), 64'd1);
      rst_n = 1'b0;
      #1;
      check($sformatf("m%0d_midreset_valid", d), 64'(valid_o), 64'd0);
      check($sformatf("m%0d_midreset_data", d), 64'(data_o), 64'd0);
      check($sformatf("m%0d_midreset_sel", d), 64'(sel_o), 64'd0);
      sb.delete();
      m_valid = 1'b0; m_ptr = 0;
      @(posedge clk);
      #1;
      check($sformatf("m%0d_inreset_nogrant", d), 64'(valid_o), 64'd0);
      rst_n = 1'b1;
      if (!valid_i[0]) offer(0, $urandom);
      select_i = 2'd0;
      step();
      check($sformatf("m%0d_postreset_sel", d), 64'(sel_o), 64'd0);

      ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
        select_i = 2'(i % 4);
        step();
      end
      check($sformatf("m%0d_sb_drained", d), 64'(sb.size()), 64'd0);
      done = 1'b1;
    end
  end

  logic        r3_rst_n;
  logic [2:0]  r3_valid_i;
  logic [2:0]  r3_ready_o;
  logic [95:0] r3_data_i;
  logic [1:0]  r3_select_i;
  logic [1:0]  r3_sel_o;
  logic        r3_valid_o;
  logic        r3_ready_i;
  logic [31:0] r3_data_o;
  bit          r3_done = 1'b0;

  mux_arb_nto1 #(.SIZE(32), .CH(3), .MODE(0)) u_dut3 (
    .clk_i    (clk),
    .rst_i    (r3_rst_n),
    .valid_i  (r3_valid_i),
    .data_i   (r3_data_i),
    .ready_o  (r3_ready_o),
    .select_i (r3_select_i),
    .valid_o  (r3_valid_o),
    .data_o   (r3_data_o),
    .sel_o    (r3_sel_o),
    .ready_i  (r3_ready_i)
  );

  initial begin
    r3_rst_n = 1'b0; r3_valid_i = 3'b111; r3_select_i = 2'd3; r3_ready_i = 1'b1;
    r3_data_i = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    @(posedge clk);
    #1;
    r3_rst_n = 1'b1;
    @(negedge clk);
    check("c3_oor_ready", 64'(r3_ready_o), 64'd0);
    @(posedge clk);
    #1;
    check("c3_oor_valid", 64'(r3_valid_o), 64'd0);
    r3_select_i = 2'd1;
    @(negedge clk);
    check("c3_sel1_ready", 64'(r3_ready_o), 64'b010);
    @(posedge clk);
    #1;
    r3_valid_i[1] = 1'b0;
    check("c3_sel1_out", {30'b0, r3_sel_o, r3_data_o}, {30'b0, 2'd1, 32'h2222_0001});
    check("c3_sel1_valid", 64'(r3_valid_o), 64'd1);
    r3_select_i = 2'd2;
    @(negedge clk);
    check("c3_sel2_ready", 64'(r3_ready_o), 64'b100);
    @(posedge clk);
    #1;
    r3_valid_i[2] = 1'b0;
    check("c3_sel2_out", {30'b0, r3_sel_o, r3_data_o}, {30'b0, 2'd2, 32'h3333_0002});
    r3_done = 1'b1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(g_dut[0].done && g_dut[1].done && r3_done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 20000) begin
      chk++;
      err++;
      $display("FAIL timeout: got %0d cycles, required completion", cyc);
    end
    #2;
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
